// File: rtl/aes_share_ctrl.sv
// Round-robin sharing of one AES-CTR keystream core between the jawny (0) and tajny (1) channels.
// Optional WAIT_TAKE watchdog enabled by defining AES_TIMEOUT_EN.
module aes_share_ctrl #(
  parameter int RES_CYCLES = 1,
  parameter int TIMEOUT    = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [95:0]  nonce0,
  input  logic [127:0] key0,
  input  logic         req1,
  input  logic [95:0]  nonce1,
  input  logic [127:0] key1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         ks_valid0,
  output logic         ks_valid1,
  output logic [127:0] ks_data,
  output logic         busy,
  output logic         timeout_err,
  output logic         aes_res,
  output logic         aes_start,
  output logic         aes_stop,
  output logic [95:0]  aes_nonce,
  output logic         aes_new_nonce,
  output logic [127:0] aes_key,
  input  logic         aes_take,
  input  logic [127:0] aes_ct
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RES,
    S_START,
    S_WAIT_TAKE,
    S_DONE,
    S_ABORT
  } state_t;

  state_t         state_reg, state_next;
  logic           winner_reg, winner_next;
  logic           last_served_reg, last_served_next;
  logic [3:0]     res_cnt_reg;
  logic           first_op_reg;
  logic [95:0]    prev_nonce_reg;
  logic [95:0]    aes_nonce_reg;
  logic [127:0]   aes_key_reg;
  logic [127:0]   ks_data_reg;
  logic           load_req;
  logic           capture_ct;
  logic           granted_req;
  logic           in_grant;

`ifdef AES_TIMEOUT_EN
  logic [15:0]    to_cnt_reg;
  logic           to_hit;
  logic           timeout_err_reg;
`endif

  assign granted_req = winner_reg ? req1 : req0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      winner_reg      <= 1'b0;
      last_served_reg <= 1'b1;
    end else begin
      state_reg       <= state_next;
      winner_reg      <= winner_next;
      last_served_reg <= last_served_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    winner_next      = winner_reg;
    last_served_next = last_served_reg;
    load_req         = 1'b0;
    capture_ct       = 1'b0;
    in_grant         = 1'b0;
    aes_res          = 1'b0;
    aes_start        = 1'b0;
    aes_stop         = 1'b0;
    aes_new_nonce    = 1'b0;
    ks_valid0        = 1'b0;
    ks_valid1        = 1'b0;
`ifdef AES_TIMEOUT_EN
    to_hit           = 1'b0;
`endif
    case (state_reg)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the channel not served last wins; otherwise the lone requester.
          winner_next = (req0 && req1) ? ~last_served_reg : req1;
          load_req    = 1'b1;
          state_next  = S_RES;
        end
      end
      S_RES: begin
        in_grant = 1'b1;
        aes_res  = 1'b1;
        if (res_cnt_reg == 4'(RES_CYCLES - 1)) state_next = S_START;
      end
      S_START: begin
        in_grant      = 1'b1;
        aes_start     = 1'b1;
        aes_new_nonce = first_op_reg || (aes_nonce_reg != prev_nonce_reg);
        state_next    = S_WAIT_TAKE;
      end
      S_WAIT_TAKE: begin
        in_grant  = 1'b1;
        aes_start = 1'b1;
        if (aes_take) begin
          capture_ct = 1'b1;
          state_next = S_DONE;
        end else if (!granted_req) begin
          state_next = S_ABORT;
        end
`ifdef AES_TIMEOUT_EN
        else if (to_cnt_reg == 16'(TIMEOUT - 1)) begin
          to_hit     = 1'b1;
          state_next = S_ABORT;
        end
`endif
      end
      S_DONE: begin
        aes_stop         = 1'b1;
        ks_valid0        = ~winner_reg;
        ks_valid1        = winner_reg;
        last_served_next = winner_reg;
        state_next       = S_IDLE;
      end
      S_ABORT: begin
        aes_stop   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign gnt0 = in_grant & ~winner_reg;
  assign gnt1 = in_grant & winner_reg;
  assign busy = (state_reg != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt_reg    <= 4'd0;
      first_op_reg   <= 1'b1;
      prev_nonce_reg <= '1;
      aes_nonce_reg  <= '0;
      aes_key_reg    <= '0;
      ks_data_reg    <= '0;
    end else begin
      if (load_req) begin
        aes_nonce_reg <= winner_next ? nonce1 : nonce0;
        aes_key_reg   <= winner_next ? key1 : key0;
      end
      res_cnt_reg <= (state_reg == S_RES) ? res_cnt_reg + 4'd1 : 4'd0;
      if (state_reg == S_START) begin
        prev_nonce_reg <= aes_nonce_reg;
        first_op_reg   <= 1'b0;
      end
      if (capture_ct) ks_data_reg <= aes_ct;
    end
  end

  assign aes_nonce = aes_nonce_reg;
  assign aes_key   = aes_key_reg;
  assign ks_data   = ks_data_reg;

`ifdef AES_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_reg      <= 16'd0;
      timeout_err_reg <= 1'b0;
    end else begin
      to_cnt_reg <= (state_reg == S_WAIT_TAKE) ? to_cnt_reg + 16'd1 : 16'd0;
      if (to_hit) timeout_err_reg <= 1'b1;
    end
  end
  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_share_ctrl.sv
// Scoreboard bench for aes_share_ctrl: expected keystream deliveries are queued by the
// stimulus and checked by an independent monitor whenever ks_valid0/ks_valid1 pulses.
module tb_aes_share_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [95:0]  nonce0 = '0, nonce1 = '0;
  logic [127:0] key0 = '0, key1 = '0;
  logic         gnt0, gnt1, ks_valid0, ks_valid1, busy, timeout_err;
  logic [127:0] ks_data;
  logic         aes_res, aes_start, aes_stop, aes_new_nonce;
  logic [95:0]  aes_nonce;
  logic [127:0] aes_key;
  logic         aes_take = 1'b0;
  logic [127:0] aes_ct = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gnt1_cycles = 0;
  int ks_pulses = 0;
  int pushes = 0;
  logic [128:0] exp_q[$];

  aes_share_ctrl #(.RES_CYCLES(1), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .nonce0(nonce0), .key0(key0),
    .req1(req1), .nonce1(nonce1), .key1(key1),
    .gnt0(gnt0), .gnt1(gnt1),
    .ks_valid0(ks_valid0), .ks_valid1(ks_valid1), .ks_data(ks_data),
    .busy(busy), .timeout_err(timeout_err),
    .aes_res(aes_res), .aes_start(aes_start), .aes_stop(aes_stop),
    .aes_nonce(aes_nonce), .aes_new_nonce(aes_new_nonce), .aes_key(aes_key),
    .aes_take(aes_take), .aes_ct(aes_ct)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every keystream delivery.
  initial begin
    logic [128:0] e;
    logic prev_v0, prev_v1;
    prev_v0 = 1'b0;
    prev_v1 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("gnt_exclusive", {127'b0, gnt0 & gnt1}, 128'd0);
        if (gnt1) gnt1_cycles++;
        if (ks_valid0 || ks_valid1) begin
          ks_pulses++;
          chk("ks_single_pulse", {127'b0, (ks_valid0 & prev_v0) | (ks_valid1 & prev_v1)}, 128'd0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL ks_unexpected: got valid0=%0b valid1=%0b data=%0h expected none",
                     ks_valid0, ks_valid1, ks_data);
          end else begin
            e = exp_q.pop_front();
            chk("ks_both", {127'b0, ks_valid0 & ks_valid1}, 128'd0);
            chk("ks_channel", {127'b0, ks_valid1}, {127'b0, e[128]});
            chk("ks_data", ks_data, e[127:0]);
            $display("ks delivery ch=%0d data=%0h", ks_valid1, ks_data);
          end
        end
      end
      prev_v0 = ks_valid0;
      prev_v1 = ks_valid1;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (aes_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Drives one operation from request to DONE; requests must already be set up.
  task automatic serve(input bit ch, input logic [127:0] ct, input int delay, input bit exp_nn);
    bit ok;
    exp_q.push_back({ch, ct});
    pushes++;
    wait_start(ok);
    chk("start_seen", {127'b0, ok}, 128'd1);
    if (!ok) return;
    chk("new_nonce", {127'b0, aes_new_nonce}, {127'b0, exp_nn});
    chk("gnt_owner", {127'b0, ch ? gnt1 : gnt0}, 128'd1);
    repeat (delay) tick();
    aes_take = 1'b1;
    aes_ct   = ct;
    tick();
    aes_take = 1'b0;
    aes_ct   = '0;
    chk("stop_pulse", {127'b0, aes_stop}, 128'd1);
    chk("gnt_drop", {126'b0, gnt1, gnt0}, 128'd0);
    $display("op ch=%0d ct=%0h nn_expected=%0b", ch, ct, exp_nn);
  endtask

  task automatic idle_gap();
    tick();
    chk("idle_gap_busy", {127'b0, busy}, 128'd0);
  endtask

  initial begin
    bit ok;
    int c0;

    // Reset state
    tick();
    tick();
    chk("rst_ctrl", {117'b0, gnt0, gnt1, busy, ks_valid0, ks_valid1, aes_res, aes_start,
                     aes_stop, aes_new_nonce, timeout_err, 1'b0}, 128'd0);
    chk("rst_ks_data", ks_data, 128'd0);
    chk("rst_aes_nonce", {32'b0, aes_nonce}, 128'd0);
    chk("rst_aes_key", aes_key, 128'd0);
    rst = 1'b0;
    tick();

    // Single jawny request
    nonce0 = 96'h1;
    key0   = '0;
    req0   = 1'b1;
    tick();
    chk("t1_gnt0", {127'b0, gnt0}, 128'd1);
    chk("t1_res", {127'b0, aes_res}, 128'd1);
    chk("t1_nonce", {32'b0, aes_nonce}, 128'd1);
    serve(1'b0, 128'hA5, 3, 1'b1);
    req0 = 1'b0;
    idle_gap();
    chk("t1_gnt1_never", 128'(gnt1_cycles), 128'd0);

    // Simultaneous requests from reset alternate jawny, tajny, jawny
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nonce0 = 96'h10;
    nonce1 = 96'h20;
    key0   = 128'h1111;
    key1   = 128'h2222;
    req0   = 1'b1;
    req1   = 1'b1;
    serve(1'b0, 128'hB1, 1, 1'b1);
    idle_gap();
    serve(1'b1, 128'hC2, 1, 1'b1);
    chk("t2_key1", aes_key, 128'h2222);
    idle_gap();
    serve(1'b0, 128'hD3, 1, 1'b1);
    req0 = 1'b0;
    req1 = 1'b0;
    idle_gap();

    // Same tajny nonce twice: new_nonce only on the first; minimum latency check
    nonce1 = 96'h666666666666666666666666;
    req1   = 1'b1;
    c0     = cyc;
    serve(1'b1, 128'hE4, 1, 1'b1);
    chk("t3_latency", 128'(cyc - c0), 128'd4);
    req1 = 1'b0;
    idle_gap();
    req1 = 1'b1;
    serve(1'b1, 128'hE5, 2, 1'b0);
    req1 = 1'b0;
    idle_gap();

    // Cancel during WAIT_TAKE
    nonce0 = 96'h1;
    req0   = 1'b1;
    serve(1'b0, 128'hA5, 1, 1'b1);
    req0 = 1'b0;
    idle_gap();
    nonce1 = 96'h777;
    req1   = 1'b1;
    wait_start(ok);
    chk("t4_start", {127'b0, ok}, 128'd1);
    tick();
    chk("t4_waiting", {127'b0, aes_start}, 128'd1);
    req1 = 1'b0;
    tick();
    chk("t4_abort_stop", {127'b0, aes_stop}, 128'd1);
    chk("t4_abort_gnt", {126'b0, gnt1, gnt0}, 128'd0);
    chk("t4_abort_valid", {127'b0, ks_valid1}, 128'd0);
    chk("t4_ks_hold", ks_data, 128'hA5);
    idle_gap();
    req0 = 1'b1;
    req1 = 1'b1;
    serve(1'b1, 128'hF6, 1, 1'b0);
    req0 = 1'b0;
    req1 = 1'b0;
    idle_gap();

    // Asynchronous reset in WAIT_TAKE
    nonce0 = 96'h55;
    req0   = 1'b1;
    wait_start(ok);
    chk("t5_start", {127'b0, ok}, 128'd1);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_ctrl", {121'b0, gnt0, gnt1, busy, aes_start, aes_stop, aes_res, ks_valid0}, 128'd0);
    chk("t5_rst_nonce", {32'b0, aes_nonce}, 128'd0);
    chk("t5_rst_ks", ks_data, 128'd0);
    req0 = 1'b0;
    tick();
    rst  = 1'b0;
    req0 = 1'b1;
    serve(1'b0, 128'h1234, 1, 1'b1);
    req0 = 1'b0;
    idle_gap();

    // Core never answers
    nonce1 = 96'h99;
    req1   = 1'b1;
    wait_start(ok);
    chk("t6_start", {127'b0, ok}, 128'd1);
`ifdef AES_TIMEOUT_EN
    repeat (8) tick();
    chk("t6_still_wait", {127'b0, aes_start}, 128'd1);
    chk("t6_err_pre", {127'b0, timeout_err}, 128'd0);
    tick();
    chk("t6_abort_stop", {127'b0, aes_stop}, 128'd1);
    chk("t6_err_set", {127'b0, timeout_err}, 128'd1);
    req1 = 1'b0;
    tick();
    tick();
    chk("t6_err_sticky", {127'b0, timeout_err}, 128'd1);
    chk("t6_idle", {127'b0, busy}, 128'd0);
`else
    repeat (20) tick();
    chk("t6_busy_hold", {127'b0, busy}, 128'd1);
    chk("t6_no_err", {127'b0, timeout_err}, 128'd0);
    chk("t6_still_start", {127'b0, aes_start}, 128'd1);
    req1 = 1'b0;
    tick();
    chk("t6_abort_stop", {127'b0, aes_stop}, 128'd1);
    idle_gap();
`endif

    repeat (3) tick();
    chk("sb_drained", 128'(exp_q.size()), 128'd0);
    chk("ks_pulse_count", 128'(ks_pulses), 128'(pushes));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_share_ctrl.md
Name: aes_share_ctrl

Overview:
- Sequences the single AES-CTR keystream core and shares it between the two frame channels: requester 0 is jawny and requester 1 is tajny.
- Each channel raises a request carrying a 96-bit nonce and a 128-bit key.
- The controller arbitrates round-robin, drives the core's reset/start/stop handshake, and returns one 128-bit keystream block to the granted channel.
- Sits between the two channel frame processors and the AES core.

Parameters:
- RES_CYCLES, 1, number of cycles aes_res is held high per operation (1..15).
- TIMEOUT, 1023, maximum WAIT_TAKE cycles before abort (watchdog only, 1..65535).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  jawny request; held high until ks_valid0 or dropped to cancel.
- nonce0  in  96  jawny nonce; stable while req0 high.
- key0  in  128  jawny key; stable while req0 high.
- req1  in  1  tajny request.
- nonce1  in  96  tajny nonce.
- key1  in  128  tajny key.
- gnt0  out  1  jawny owns core (level).
- gnt1  out  1  tajny owns core (level).
- ks_valid0  out  1  one-cycle pulse: ks_data valid for jawny.
- ks_valid1  out  1  one-cycle pulse: ks_data valid for tajny.
- ks_data  out  128  registered keystream block, held until next capture.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky watchdog flag.
- aes_res  out  1  core reset.
- aes_start  out  1  core start (level).
- aes_stop  out  1  core stop pulse.
- aes_nonce  out  96  registered nonce to core.
- aes_new_nonce  out  1  one-cycle pulse concurrent with the first aes_start cycle.
- aes_key  out  128  registered key to core.
- aes_take  in  1  core keystream valid.
- aes_ct  in  128  core keystream block.

Behaviour:
- Reset: all outputs 0, ks_data 0, state IDLE, last-served pointer = 1 (so jawny wins first tie), prev-nonce register = all ones, first-op flag set.
- States: IDLE, RES, START, WAIT_TAKE, DONE, ABORT.
- IDLE:
  - If any req is high, pick the winner. Only one requesting: that one. Both requesting: the one not last served.
  - Latch winner, nonce and key into aes_nonce/aes_key; assert that gnt next cycle; go to RES with counter 0.
- RES:
  - aes_res=1 for exactly RES_CYCLES cycles, then START.
- START:
  - aes_start=1 (held through WAIT_TAKE).
  - aes_new_nonce=1 this cycle only if the first-op flag is set or aes_nonce differs from prev-nonce.
  - Update prev-nonce, clear first-op, go to WAIT_TAKE.
- WAIT_TAKE:
  - On aes_take: capture aes_ct into ks_data, then DONE.
  - If the granted req drops before aes_take: ABORT.
  - aes_take in any other state is ignored.
- DONE (1 cycle):
  - Pulse ks_valid of the winner, aes_stop=1, aes_start=0, drop gnt.
  - Update last-served; go to IDLE.
- ABORT (1 cycle):
  - aes_stop=1, aes_start=0, drop gnt, no ks_valid, ks_data unchanged.
  - last-served not updated; go to IDLE.
- gnt0 and gnt1 are never high simultaneously.
- Minimum latency, req to ks_valid with aes_take on the first WAIT_TAKE cycle and RES_CYCLES=1: req sampled in cycle 0, ks_valid in cycle 4.
- Back-to-back: a request held through DONE is arbitrated in the following IDLE cycle. One IDLE cycle always separates operations.
- Async reset mid-operation returns everything to reset values immediately. No ks_valid is emitted.

Optional Feature:
- AES_TIMEOUT_EN defined:
  - 16-bit counter runs in WAIT_TAKE.
  - Reaching TIMEOUT without aes_take: go to ABORT and set timeout_err sticky until rst.
- Undefined:
  - No counter; WAIT_TAKE waits indefinitely; timeout_err tied 0.

Test Plan:
- Single jawny request: req0=1, nonce0=96'h1, key0=0, aes_take pulsed 3 cycles after aes_start rises, aes_ct=128'hA5 -> gnt0 high, aes_new_nonce pulse, ks_data=128'hA5, ks_valid0 single pulse, aes_stop pulse, gnt1 never high.
- Simultaneous requests from reset: req0=req1=1 -> jawny served first, tajny next with one IDLE gap. Third round with both held -> jawny again (alternation).
- Same nonce twice from tajny (nonce1=96'h66..66) -> aes_new_nonce on the first operation only; the second operation shows aes_start without aes_new_nonce.
- Cancel: req1 dropped during WAIT_TAKE -> ABORT; aes_stop pulse, no ks_valid1, ks_data keeps previous 128'hA5, next tie still favours tajny.
- Async rst asserted in WAIT_TAKE -> all outputs 0 same cycle. After release, a new req0 runs normally and aes_new_nonce fires.
- With AES_TIMEOUT_EN, TIMEOUT=8, aes_take never asserted -> ABORT after 8 WAIT_TAKE cycles, timeout_err=1 and stays 1. Without the macro, busy stays high and timeout_err=0.
